// File: rtl/unique_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unique_req_arbiter
// Brief   : N-way arbiter with a registered one-hot grant, fixed-priority or
//           round-robin policy and bounded ownership. Optional collision
//           flagging enabled by defining UNIQUE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module unique_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     mode,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     collision,
    output logic [CNT_W-1:0]         collision_cnt
);

    localparam int c_ID_W   = $clog2(N_REQ);
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_ID_W-1:0]   c_LAST_ID  = c_ID_W'(N_REQ - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_REQ-1:0]      r_gnt;
    logic [N_REQ-1:0]      w_gnt_nxt;
    logic [c_ID_W-1:0]     r_gnt_id;
    logic [c_ID_W-1:0]     w_id_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_ID_W-1:0]     r_rr_ptr;
    logic [c_ID_W-1:0]     w_ptr_nxt;

    logic [N_REQ-1:0]      w_hi_mask;
    logic [N_REQ-1:0]      w_req_hi;
    logic [c_ID_W-1:0]     w_fp_win;
    logic [c_ID_W-1:0]     w_rr_win;
    logic [c_ID_W-1:0]     w_win;
    logic                  w_owner_req;

    function automatic logic [c_ID_W-1:0] f_lowest(input logic [N_REQ-1:0] v);
        logic [c_ID_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = c_ID_W'(i);
        end
        return idx;
    endfunction

    // Round robin: search requests at/above the pointer first, else wrap to
    // the lowest requester overall.
    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_hi_mask[i] = (c_ID_W'(i) >= r_rr_ptr);
        end
    end

    assign w_req_hi    = req & w_hi_mask;
    assign w_fp_win    = f_lowest(req);
    assign w_rr_win    = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(req);
    assign w_win       = mode ? w_rr_win : w_fp_win;
    assign w_owner_req = |(req & r_gnt);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_gnt_id;
        w_hold_nxt  = r_hold_cnt;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_id_nxt    = w_win;
                    w_hold_nxt  = c_HOLD_W'(1);
                    w_ptr_nxt   = (w_win == c_LAST_ID) ? '0 : w_win + c_ID_W'(1);
                end
            end
            GRANT: begin
                if (!w_owner_req || (r_hold_cnt == c_HOLD_MAX)) begin
                    w_state_nxt = REL;
                    w_gnt_nxt   = '0;
                    w_id_nxt    = '0;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            REL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_id_nxt    = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_id_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rr_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;

`ifdef UNIQUE_CHECK_EN
    logic             w_multi_req;
    logic             w_collide;
    logic             r_collision;
    logic [CNT_W-1:0] r_coll_cnt;

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign w_multi_req = |(req & (req - N_REQ'(1)));
    assign w_collide   = (r_state == IDLE) && w_multi_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_collision <= w_collide;
            if (w_collide && (r_coll_cnt != '1)) begin
                r_coll_cnt <= r_coll_cnt + CNT_W'(1);
            end
        end
    end

    assign collision     = r_collision;
    assign collision_cnt = r_coll_cnt;
`else
    assign collision     = 1'b0;
    assign collision_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unique_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unique_req_arbiter
// Brief   : Scoreboard bench for unique_req_arbiter; two instances
//           (MAX_HOLD 8 and 1) share one stimulus stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_unique_req_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
`ifdef UNIQUE_CHECK_EN
    localparam bit UC = 1'b1;
`else
    localparam bit UC = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic       gv;
        logic [1:0] id;
        logic       coll;
        logic [1:0] cnt;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic       mode  = 1'b0;

    logic [3:0] gnt_a, gnt_b;
    logic       gv_a, gv_b;
    logic [1:0] id_a, id_b;
    logic       coll_a, coll_b;
    logic [1:0] cnt_a, cnt_b;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t zero = '0;

    // Reference model state, one slot per instance
    int hold_lim[2] = '{8, 1};
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];
    int m_cnt[2];
    bit m_rel[2];
    bit m_coll[2];

    unique_req_arbiter #(.N_REQ(N), .MAX_HOLD(8), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a),
        .collision(coll_a), .collision_cnt(cnt_a)
    );

    unique_req_arbiter #(.N_REQ(N), .MAX_HOLD(1), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b),
        .collision(coll_b), .collision_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_held[u]  = 0;
            m_ptr[u]   = 0;
            m_cnt[u]   = 0;
            m_rel[u]   = 1'b0;
            m_coll[u]  = 1'b0;
        end
    endtask

    function automatic int pick(int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = mode ? (ptr + k) % N : k;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(int u);
        int w;
        m_coll[u] = 1'b0;
        if (m_owner[u] >= 0) begin
            if (!req[m_owner[u]] || m_held[u] == hold_lim[u]) begin
                m_owner[u] = -1;
                m_rel[u]   = 1'b1;
            end else begin
                m_held[u]++;
            end
        end else if (m_rel[u]) begin
            m_rel[u] = 1'b0;
        end else if (req != 0) begin
            w          = pick(m_ptr[u]);
            m_owner[u] = w;
            m_held[u]  = 1;
            m_ptr[u]   = (w + 1) % N;
            if (UC && $countones(req) > 1) begin
                m_coll[u] = 1'b1;
                if (m_cnt[u] < (1 << CW) - 1) m_cnt[u]++;
            end
        end
    endtask

    function automatic exp_t expect_of(int u);
        exp_t e;
        e = '0;
        if (m_owner[u] >= 0) begin
            e.gnt = 4'(1 << m_owner[u]);
            e.gv  = 1'b1;
            e.id  = 2'(m_owner[u]);
        end
        e.coll = m_coll[u];
        e.cnt  = 2'(m_cnt[u]);
        return e;
    endfunction

    task automatic compare(string name, exp_t exp, exp_t got);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got gnt=%b v=%b id=%0d coll=%b cnt=%0d, expected gnt=%b v=%b id=%0d coll=%b cnt=%0d",
                     name, $time, got.gnt, got.gv, got.id, got.coll, got.cnt,
                     exp.gnt, exp.gv, exp.id, exp.coll, exp.cnt);
        end
    endtask

    // Expected responses are produced from the inputs seen at each edge
    always @(posedge clk) begin
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
            q_a.push_back(expect_of(0));
            q_b.push_back(expect_of(1));
        end
    end

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) compare("dut_a", q_a.pop_front(), {gnt_a, gv_a, id_a, coll_a, cnt_a});
        if (q_b.size() > 0) compare("dut_b", q_b.pop_front(), {gnt_b, gv_b, id_b, coll_b, cnt_b});
    end

    task automatic drive(int n, logic [3:0] r, logic m);
        req  = r;
        mode = m;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare("reset_a", zero, {gnt_a, gv_a, id_a, coll_a, cnt_a});
        compare("reset_b", zero, {gnt_b, gv_b, id_b, coll_b, cnt_b});
        rst_n = 1'b1;
        drive(2, 4'b0000, 1'b0);

        // single requester, released after 3 cycles
        drive(3, 4'b0100, 1'b0);
        drive(4, 4'b0000, 1'b0);
        // fixed priority starvation with forced release
        drive(24, 4'b1010, 1'b0);
        drive(3, 4'b0000, 1'b0);
        // round robin rotation
        drive(45, 4'b1111, 1'b1);
        drive(4, 4'b0000, 1'b0);

        // asynchronous reset while dut_a is 4 cycles into a grant
        drive(4, 4'b0100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        compare("async_rst_a", zero, {gnt_a, gv_a, id_a, coll_a, cnt_a});
        compare("async_rst_b", zero, {gnt_b, gv_b, id_b, coll_b, cnt_b});
        @(negedge clk);
        rst_n = 1'b1;
        drive(20, 4'b1111, 1'b1);
        drive(3, 4'b0000, 1'b0);

        // repeated multi-request rounds to exercise the collision counter
        for (int r = 0; r < 5; r++) begin
            drive(1, 4'b0011, 1'b0);
            drive(3, 4'b0000, 1'b0);
        end

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            @(negedge clk);
        end

        drive(3, 4'b0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
